// File: rtl/ripple_monitor.sv
// ripple_monitor: receive-side checker for the rippling-LED display.
// Ports: clk, reset (async, active-high), led0..led7 in;
//   pos, valid, locked, dir, step_err, err_count out.
// Optional feature: define RIPPLE_BIDIR_EN to accept downward ripples.
module ripple_monitor #(
   parameter int STEP_CYCLES = 25000000,
   parameter int TOL         = 2,
   parameter int CNT_W       = 28
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       led0,
   input  logic       led1,
   input  logic       led2,
   input  logic       led3,
   input  logic       led4,
   input  logic       led5,
   input  logic       led6,
   input  logic       led7,
   output logic [2:0] pos,
   output logic       valid,
   output logic       locked,
   output logic       dir,
   output logic       step_err,
   output logic [7:0] err_count
);

   typedef enum logic {ACQUIRE, TRACK} state_t;

   localparam logic [CNT_W-1:0] DW_LO = CNT_W'(STEP_CYCLES - TOL);
   localparam logic [CNT_W-1:0] DW_HI = CNT_W'(STEP_CYCLES + TOL);

   state_t           state, state_n;
   logic [7:0]       l_q, l_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       prev_pos;
   logic             prev_ok;
   logic             change;
   logic             err;
   logic [2:0]       up;
   logic [2:0]       exp_pos;

   // One-hot decode; anything else (incl. X/Z) is invalid with pos=0
   always_comb begin
      pos   = 3'd0;
      valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (l_q == (8'h01 << i)) begin
            pos   = 3'(i);
            valid = 1'b1;
         end
      end
   end

   assign change = (l_q != l_prev);
   assign locked = (state == TRACK);
   assign up     = prev_pos + 3'd1;

`ifdef RIPPLE_BIDIR_EN
   logic       dir_q, dir_n;
   logic [2:0] dn;

   assign dn      = prev_pos - 3'd1;
   assign dir     = dir_q;
   assign exp_pos = dir_q ? dn : up;
`else
   assign dir     = 1'b0;
   assign exp_pos = up;
`endif

   always_comb begin
      state_n = state;
      err     = 1'b0;
`ifdef RIPPLE_BIDIR_EN
      dir_n   = dir_q;
`endif
      case (state)
         ACQUIRE: begin
            // First step of a ripple is taken on adjacency alone
            if (change && valid && prev_ok) begin
               if (pos == up) begin
                  state_n = TRACK;
`ifdef RIPPLE_BIDIR_EN
                  dir_n   = 1'b0;
               end else if (pos == dn) begin
                  state_n = TRACK;
                  dir_n   = 1'b1;
`endif
               end
            end
         end
         TRACK: begin
            if (change) begin
               if (!valid)
                  err = 1'b1;
               else if (pos != exp_pos)
                  err = 1'b1;
               else if (cnt < DW_LO || cnt > DW_HI)
                  err = 1'b1;
            end else if (cnt == DW_HI) begin
               // Dwell about to exceed the upper bound
               err = 1'b1;
            end
            if (err)
               state_n = ACQUIRE;
         end
         default: state_n = ACQUIRE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_q       <= 8'h00;
         l_prev    <= 8'h00;
         cnt       <= '0;
         prev_pos  <= 3'd0;
         prev_ok   <= 1'b0;
         state     <= ACQUIRE;
         step_err  <= 1'b0;
         err_count <= 8'h00;
      end else begin
         l_q    <= {led7, led6, led5, led4,
                    led3, led2, led1, led0};
         l_prev <= l_q;
         if (change)
            cnt <= CNT_W'(1);
         else if (cnt != '1)
            cnt <= cnt + CNT_W'(1);
         // The latest pattern is always the reference
         // for the next adjacency test
         if (change) begin
            prev_pos <= pos;
            prev_ok  <= valid;
         end
         state    <= state_n;
         step_err <= err;
         if (err && err_count != 8'hff)
            err_count <= err_count + 8'd1;
      end
   end

`ifdef RIPPLE_BIDIR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         dir_q <= 1'b0;
      else
         dir_q <= dir_n;
   end
`endif

endmodule

// File: tb/tb_ripple_monitor.sv
// tb_ripple_monitor: directed self-checking bench
// for ripple_monitor with STEP_CYCLES=4, TOL=0, CNT_W=4.
module tb_ripple_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] leds = 8'h00;
   logic [2:0] pos;
   logic       valid, locked, dir, step_err;
   logic [7:0] err_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ripple_monitor #(
      .STEP_CYCLES(4),
      .TOL(0),
      .CNT_W(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .led0(leds[0]),
      .led1(leds[1]),
      .led2(leds[2]),
      .led3(leds[3]),
      .led4(leds[4]),
      .led5(leds[5]),
      .led6(leds[6]),
      .led7(leds[7]),
      .pos(pos),
      .valid(valid),
      .locked(locked),
      .dir(dir),
      .step_err(step_err),
      .err_count(err_count)
   );

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h",
                tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [7:0] oh(input int k);
      logic [7:0] one;
      one = 8'h01;
      return one << k;
   endfunction

   task automatic rst_dut();
      reset = 1'b1;
      leds  = 8'h00;
      ticks(2);
      reset = 1'b0;
   endtask

   // Leaves the monitor locked at led k with 3 cycles of dwell used
   task automatic lock_at(input int k);
      rst_dut();
      leds = oh((k + 7) % 8);
      ticks(4);
      leds = oh(k);
      ticks(4);
   endtask

   // One lock followed by a skip error
   task automatic force_err();
      leds = oh(0);
      tick();
      leds = oh(1);
      ticks(2);
      leds = oh(3);
      ticks(2);
   endtask

   initial begin
      // Reset state
      ticks(2);
      chk("rst_pos", 8'(pos), 8'd0);
      chk("rst_valid", 8'(valid), 8'd0);
      chk("rst_locked", 8'(locked), 8'd0);
      chk("rst_dir", 8'(dir), 8'd0);
      chk("rst_step_err", 8'(step_err), 8'd0);
      chk("rst_err_count", err_count, 8'd0);

      // Clean ripple, two laps plus the closing led0
      rst_dut();
      for (int i = 0; i < 17; i++) begin
         leds = oh(i % 8);
         tick();
         chk("clean_pos", 8'(pos), 8'(i % 8));
         chk("clean_valid", 8'(valid), 8'd1);
         tick();
         chk("clean_step_err", 8'(step_err), 8'd0);
         chk("clean_locked", 8'(locked), (i >= 1) ? 8'd1 : 8'd0);
         ticks(2);
         chk("clean_step_err2", 8'(step_err), 8'd0);
      end
      chk("clean_err_count", err_count, 8'd0);
      chk("clean_dir", 8'(dir), 8'd0);

      // Skip led2 -> led4
      lock_at(2);
      chk("skip_locked0", 8'(locked), 8'd1);
      leds = oh(4);
      tick();
      chk("skip_err_early", 8'(step_err), 8'd0);
      tick();
      chk("skip_step_err", 8'(step_err), 8'd1);
      chk("skip_err_count", err_count, 8'd1);
      chk("skip_locked", 8'(locked), 8'd0);
      tick();
      chk("skip_pulse_end", 8'(step_err), 8'd0);
      leds = oh(5);
      ticks(2);
      chk("skip_relock", 8'(locked), 8'd1);
      chk("skip_relock_err", 8'(step_err), 8'd0);
      chk("skip_relock_cnt", err_count, 8'd1);

      // Long dwell at led3 -> timeout
      lock_at(3);
      tick();
      chk("long_err_early", 8'(step_err), 8'd0);
      chk("long_locked0", 8'(locked), 8'd1);
      tick();
      chk("long_step_err", 8'(step_err), 8'd1);
      chk("long_err_count", err_count, 8'd1);
      chk("long_locked", 8'(locked), 8'd0);
      tick();
      chk("long_pulse_end", 8'(step_err), 8'd0);
      leds = oh(4);
      ticks(2);
      chk("long_relock", 8'(locked), 8'd1);
      chk("long_relock_cnt", err_count, 8'd1);

      // Double LED after led1
      lock_at(1);
      leds = 8'h06;
      tick();
      chk("dbl_valid", 8'(valid), 8'd0);
      chk("dbl_pos", 8'(pos), 8'd0);
      chk("dbl_err_early", 8'(step_err), 8'd0);
      tick();
      chk("dbl_step_err", 8'(step_err), 8'd1);
      chk("dbl_err_count", err_count, 8'd1);
      chk("dbl_locked", 8'(locked), 8'd0);
      force_err();
      chk("force_first_cnt", err_count, 8'd2);
      for (int j = 0; j < 255; j++) force_err();
      chk("sat_step_err", 8'(step_err), 8'd1);
      chk("sat_err_count", err_count, 8'd255);

      // Reset in the middle of TRACK
      rst_dut();
      for (int j = 0; j < 3; j++) force_err();
      leds = oh(0);
      tick();
      leds = oh(1);
      ticks(2);
      chk("mid_locked", 8'(locked), 8'd1);
      chk("mid_err_count", err_count, 8'd3);
      chk("mid_valid", 8'(valid), 8'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_pos", 8'(pos), 8'd0);
      chk("async_valid", 8'(valid), 8'd0);
      chk("async_locked", 8'(locked), 8'd0);
      chk("async_dir", 8'(dir), 8'd0);
      chk("async_step_err", 8'(step_err), 8'd0);
      chk("async_err_count", err_count, 8'd0);
      tick();
      reset = 1'b0;
      leds = oh(0);
      ticks(4);
      leds = oh(1);
      ticks(2);
      chk("post_rst_locked", 8'(locked), 8'd1);
      chk("post_rst_err", 8'(step_err), 8'd0);
      chk("post_rst_cnt", err_count, 8'd0);

      // Downward ripple 7 -> 6 -> 5
      rst_dut();
      leds = oh(7);
      ticks(4);
      for (int k = 6; k >= 5; k--) begin
         leds = oh(k);
         tick();
         chk("down_pos", 8'(pos), 8'(k));
         tick();
         chk("down_step_err", 8'(step_err), 8'd0);
         ticks(2);
      end
`ifdef RIPPLE_BIDIR_EN
      chk("down_locked", 8'(locked), 8'd1);
      chk("down_dir", 8'(dir), 8'd1);
`else
      chk("down_locked", 8'(locked), 8'd0);
      chk("down_dir", 8'(dir), 8'd0);
`endif
      chk("down_err_count", err_count, 8'd0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/ripple_monitor.md
# ripple_monitor

- Receive-side checker for the rippling-LED display: observes the eight LED lines, decodes which LED is lit and checks each step.
- Each step must go to the adjacent LED, including the 7↔0 wrap, and must occur after the expected dwell time.
- Reports lock status, single-cycle error pulses and a saturating error count.
- Sits beside the LED driver on the same clock for on-board self-check and simulation scoreboarding.

## Interface
- STEP_CYCLES, 25000000: expected dwell of each LED, in clk cycles.
- TOL, 2: allowed ± deviation of the measured dwell from STEP_CYCLES.
- CNT_W, 28: dwell counter width; must hold STEP_CYCLES+TOL+1.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- led0 … led7  in  1 each  observed LED lines, synchronous to clk.
- pos  out  3  index of the lit LED in the sampled pattern.
- valid  out  1  sampled pattern is one-hot.
- locked  out  1  monitor is in TRACK.
- dir  out  1  0 = upward (0→1→…→7→0), 1 = downward.
- step_err  out  1  one-cycle error pulse.
- err_count  out  8  errors seen, saturates at 255.

## Operation
- **Input register:** l_q samples {led7..led0} every cycle. pos and valid decode l_q combinationally. pos=0 when l_q is not one-hot.
- **Change detection:** change = (l_q ≠ value of l_q one cycle earlier).
- **Dwell counter cnt:**
  - Set to 1 on a change.
  - Otherwise increments, saturating at all-ones.
  - On a change, the measured dwell is the cnt value before reload.
- **Adjacency:** next = (prev_pos+1) mod 8 when dir=0; (prev_pos−1) mod 8 when dir=1.
- **State ACQUIRE** (reset state, locked=0):
  - Takes a change from a one-hot pattern to an adjacent one-hot pattern in the upward direction → TRACK.
  - dir is set from that step.
  - The dwell of this first step is not checked.
  - Any other change, or a non-one-hot pattern, is ignored; no error is raised.
- **State TRACK** (locked=1). Error on:
  - (a) change to a non-one-hot pattern;
  - (b) change to a non-adjacent position;
  - (c) change with |dwell − STEP_CYCLES| > TOL;
  - (d) timeout: no change while cnt == STEP_CYCLES+TOL, i.e. the dwell has reached STEP_CYCLES+TOL+1.
- **On any error:**
  - step_err=1 for exactly one cycle.
  - err_count +1, saturating at 255.
  - State → ACQUIRE.
- **Error precedence:** one error per event. Conditions (a)–(c) are exclusive with (d) in the same cycle, since (d) requires no change.
- **Legal change in TRACK:** stay in TRACK; prev_pos ← pos.

## Timing
- **Reset values:** l_q=0, cnt=0, prev_pos=0, pos=0, valid=0, locked=0, dir=0, step_err=0, err_count=0, state=ACQUIRE.
- **Reset behaviour:** reset clears all state immediately, without waiting for a clock edge. It may assert mid-TRACK; after release the monitor reacquires from scratch.
- **LED to pos/valid:** 1 cycle. An LED change set up before edge k appears on pos/valid after edge k.
- **Error and lock outputs:** step_err, locked, dir and err_count update at edge k+1, i.e. 2 cycles after the LED change. Timeout errors follow the same one-edge register delay after the decision cycle.
- **After an error:** the step that caused the error, or the current pattern after a timeout, becomes prev_pos. The next legal adjacent change relocks with no dwell check.
- **Wrap:** 7→0 (dir=0) and 0→7 (dir=1) are legal adjacent steps.
- **Unknown inputs:** X/Z on an LED line is treated as non-one-hot for valid.

## Configuration
- **RIPPLE_BIDIR_EN defined:**
  - ACQUIRE also accepts a downward adjacent step and sets dir=1.
  - In TRACK, steps must match the latched dir; a direction reversal is error (b).
- **RIPPLE_BIDIR_EN undefined:**
  - dir is tied 0.
  - Downward steps are ignored in ACQUIRE and count as error (b) in TRACK.

## Test plan
All scenarios use STEP_CYCLES=4, TOL=0, CNT_W=4.
- **Clean ripple:** led0→led1→…→led7→led0, 4 cycles per LED, two full laps → locked=1 from the first step onward, pos steps 0..7..0, step_err never high, err_count=0.
- **Skip:** locked at led2, then led4 after 4 cycles → one step_err pulse, err_count=1, locked=0. A following led5 after any dwell relocks with no error.
- **Long dwell:** locked at led3, held for 6 cycles → step_err pulses once, when the dwell reaches 5 (timeout), err_count=1, locked=0. The subsequent step to led4 relocks.
- **Double LED:** locked at led1, then pattern 0x06 at the 4-cycle mark → valid=0 and pos=0 one cycle later; step_err one cycle after that; err_count=1. Additionally, 256 forced errors leave err_count=255.
- **Reset mid-operation:** locked with err_count=3, assert reset between clock edges → every output is 0 immediately, before the next edge. After release, a clean ripple relocks after one step.
- **Direction:** led7→led6→led5 at 4 cycles each.
  - Macro defined: locked=1, dir=1, no errors.
  - Macro undefined: locked stays 0, no step_err, err_count=0.
